// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences each instruction
// through FETCH/DECODE/EXEC/MEM/WB states and drives ALU encodings, enables and selects.
module multicycle_ctrl #(
    parameter int IMEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_instr,
    input  logic        in_zero,
    output logic [1:0]  out_alu_option,
    output logic        out_alu_src,
    output logic [1:0]  out_ext_op,
    output logic        out_pc_write,
    output logic [1:0]  out_pc_src,
    output logic        out_ir_write,
    output logic        out_grf_write,
    output logic        out_reg_dst,
    output logic        out_mem_to_reg,
    output logic        out_dm_write,
    output logic        out_illegal,
    output logic        out_retire,
    output logic [3:0]  out_state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC   = 4'd2;
    localparam logic [3:0] S_ALUWB  = 4'd3;
    localparam logic [3:0] S_MEMADR = 4'd4;
    localparam logic [3:0] S_MEMRD  = 4'd5;
    localparam logic [3:0] S_MEMWB  = 4'd6;
    localparam logic [3:0] S_MEMWR  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;

    localparam logic [3:0] WAIT_MAX = 4'(IMEM_WAIT);

    logic [3:0] r_state;
    logic [3:0] r_wait;
    logic [3:0] w_next;

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_is_r, w_addu, w_subu, w_ori, w_lw, w_sw, w_beq, w_lui, w_j;
    logic       w_nop, w_alu_grp, w_legal, w_capture;

    assign w_op      = in_instr[31:26];
    assign w_fn      = in_instr[5:0];
    assign w_is_r    = (w_op == 6'b000000);
    assign w_addu    = w_is_r && (w_fn == 6'b100001);
    assign w_subu    = w_is_r && (w_fn == 6'b100011);
    assign w_ori     = (w_op == 6'b001101);
    assign w_lw      = (w_op == 6'b100011);
    assign w_sw      = (w_op == 6'b101011);
    assign w_beq     = (w_op == 6'b000100);
    assign w_lui     = (w_op == 6'b001111);
    assign w_j       = (w_op == 6'b000010);
    assign w_nop     = (in_instr == 32'h0000_0000);
    assign w_alu_grp = w_addu || w_subu || w_ori || w_lui;
    assign w_legal   = w_alu_grp || w_lw || w_sw || w_beq || w_j;
    assign w_capture = (r_wait == WAIT_MAX);
    assign out_state = r_state;

    // State register and FETCH stall counter; the counter is zero whenever FETCH is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_wait  <= 4'd0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_FETCH) && !w_capture) begin
                r_wait <= r_wait + 4'd1;
            end else begin
                r_wait <= 4'd0;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = w_capture ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (w_nop) begin
                    w_next = S_FETCH;
                end else if (w_alu_grp) begin
                    w_next = S_EXEC;
                end else if (w_lw || w_sw) begin
                    w_next = S_MEMADR;
                end else if (w_beq) begin
                    w_next = S_BRANCH;
                end else if (w_j) begin
                    w_next = S_JUMP;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_EXEC:   w_next = S_ALUWB;
            S_MEMADR: w_next = w_lw ? S_MEMRD : (w_sw ? S_MEMWR : S_FETCH);
            S_MEMRD:  w_next = S_MEMWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Moore outputs; reset forces every enable and select to its idle value.
    always_comb begin
        out_alu_option = 2'b00;
        out_alu_src    = 1'b0;
        out_ext_op     = 2'b00;
        out_pc_write   = 1'b0;
        out_pc_src     = 2'b00;
        out_ir_write   = 1'b0;
        out_grf_write  = 1'b0;
        out_reg_dst    = 1'b0;
        out_mem_to_reg = 1'b0;
        out_dm_write   = 1'b0;
        out_illegal    = 1'b0;
        out_retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_capture) begin
                    out_ir_write = 1'b1;
                    out_pc_write = 1'b1;
                end else begin
                    out_ir_write = 1'b0;
                end
            end
            S_DECODE: begin
                if (w_nop) begin
                    out_retire = 1'b1;
                end else if (!w_legal) begin
                    out_illegal = 1'b1;
                    out_retire  = 1'b1;
                end else begin
                    out_retire = 1'b0;
                end
            end
            S_EXEC, S_ALUWB: begin
                if (w_subu) begin
                    out_alu_option = 2'b01;
                end else if (w_ori || w_lui) begin
                    out_alu_option = 2'b10;
                    out_alu_src    = 1'b1;
                    out_ext_op     = w_lui ? 2'b10 : 2'b00;
                end else begin
                    out_alu_option = 2'b00;
                end
                if (r_state == S_ALUWB) begin
                    out_grf_write = 1'b1;
                    out_reg_dst   = w_is_r;
                    out_retire    = 1'b1;
                end else begin
                    out_retire = 1'b0;
                end
            end
            S_MEMADR, S_MEMRD, S_MEMWR: begin
                out_alu_src = 1'b1;
                out_ext_op  = 2'b01;
                if (r_state == S_MEMWR) begin
                    out_dm_write = 1'b1;
                    out_retire   = 1'b1;
                end else begin
                    out_dm_write = 1'b0;
                end
            end
            S_MEMWB: begin
                out_grf_write  = 1'b1;
                out_mem_to_reg = 1'b1;
                out_retire     = 1'b1;
            end
            S_BRANCH: begin
                out_alu_option = 2'b01;
                out_ext_op     = 2'b01;
                out_pc_src     = 2'b01;
                out_pc_write   = in_zero;
                out_retire     = 1'b1;
            end
            S_JUMP: begin
                out_pc_src   = 2'b10;
                out_pc_write = 1'b1;
                out_retire   = 1'b1;
            end
            default: out_retire = 1'b0;
        endcase
        if (reset) begin
            out_alu_option = 2'b00;
            out_alu_src    = 1'b0;
            out_ext_op     = 2'b00;
            out_pc_write   = 1'b0;
            out_pc_src     = 2'b00;
            out_ir_write   = 1'b0;
            out_grf_write  = 1'b0;
            out_reg_dst    = 1'b0;
            out_mem_to_reg = 1'b0;
            out_dm_write   = 1'b0;
            out_illegal    = 1'b0;
            out_retire     = 1'b0;
        end else begin
            out_retire = out_retire;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: expected per-cycle output vectors are built from an
// instruction-class table and compared against two instances (IMEM_WAIT 0 and 3).
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] state;
        logic [1:0] opt;
        logic       src;
        logic [1:0] ext;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       grf;
        logic       rd;
        logic       m2r;
        logic       dm;
        logic       ill;
        logic       ret;
    } outv_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_instr = 32'h0;
    logic        in_zero = 1'b0;
    logic        sel = 1'b0;
    int          ncmp = 0;
    int          nfail = 0;
    outv_t       exp_q[$];

    logic [1:0] opt0, ext0, pcs0, opt3, ext3, pcs3;
    logic       src0, pcw0, irw0, grf0, rd0, m2r0, dm0, ill0, ret0;
    logic       src3, pcw3, irw3, grf3, rd3, m2r3, dm3, ill3, ret3;
    logic [3:0] st0, st3;
    outv_t      obs0, obs3, obs;

    always #5 clk = ~clk;

    multicycle_ctrl #(.IMEM_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .in_instr(in_instr), .in_zero(in_zero),
        .out_alu_option(opt0), .out_alu_src(src0), .out_ext_op(ext0),
        .out_pc_write(pcw0), .out_pc_src(pcs0), .out_ir_write(irw0),
        .out_grf_write(grf0), .out_reg_dst(rd0), .out_mem_to_reg(m2r0),
        .out_dm_write(dm0), .out_illegal(ill0), .out_retire(ret0), .out_state(st0)
    );

    multicycle_ctrl #(.IMEM_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .in_instr(in_instr), .in_zero(in_zero),
        .out_alu_option(opt3), .out_alu_src(src3), .out_ext_op(ext3),
        .out_pc_write(pcw3), .out_pc_src(pcs3), .out_ir_write(irw3),
        .out_grf_write(grf3), .out_reg_dst(rd3), .out_mem_to_reg(m2r3),
        .out_dm_write(dm3), .out_illegal(ill3), .out_retire(ret3), .out_state(st3)
    );

    assign obs0 = {st0, opt0, src0, ext0, pcw0, pcs0, irw0, grf0, rd0, m2r0, dm0, ill0, ret0};
    assign obs3 = {st3, opt3, src3, ext3, pcw3, pcs3, irw3, grf3, rd3, m2r3, dm3, ill3, ret3};
    assign obs  = sel ? obs3 : obs0;

    function automatic outv_t mk(input logic [3:0] s);
        outv_t r;
        r = '0;
        r.state = s;
        return r;
    endfunction

    // Reference: list of cycles an instruction must take, with each cycle's outputs.
    function automatic void build(input logic [31:0] ins, input logic z, input int w);
        outv_t e;
        logic [5:0] op, fn;
        logic is_r, addu, subu, ori, lw, sw, beq, lui, jj;
        op = ins[31:26]; fn = ins[5:0];
        is_r = (op == 6'd0);
        addu = is_r && fn == 6'h21; subu = is_r && fn == 6'h23;
        ori = op == 6'h0D; lw = op == 6'h23; sw = op == 6'h2B;
        beq = op == 6'h04; lui = op == 6'h0F; jj = op == 6'h02;
        exp_q.delete();
        for (int i = 0; i < w; i++) exp_q.push_back(mk(4'd0));
        e = mk(4'd0); e.irw = 1'b1; e.pcw = 1'b1; exp_q.push_back(e);
        e = mk(4'd1);
        if (ins == 32'h0) e.ret = 1'b1;
        else if (!(addu || subu || ori || lui || lw || sw || beq || jj)) begin
            e.ill = 1'b1; e.ret = 1'b1;
        end
        exp_q.push_back(e);
        if (ins != 32'h0 && (addu || subu || ori || lui)) begin
            e = mk(4'd2);
            e.opt = subu ? 2'b01 : ((ori || lui) ? 2'b10 : 2'b00);
            e.src = ori || lui;
            e.ext = lui ? 2'b10 : 2'b00;
            exp_q.push_back(e);
            e.state = 4'd3; e.grf = 1'b1; e.rd = is_r; e.ret = 1'b1;
            exp_q.push_back(e);
        end else if (lw || sw) begin
            e = mk(4'd4); e.src = 1'b1; e.ext = 2'b01; exp_q.push_back(e);
            if (lw) begin
                e.state = 4'd5; exp_q.push_back(e);
                e = mk(4'd6); e.grf = 1'b1; e.m2r = 1'b1; e.ret = 1'b1; exp_q.push_back(e);
            end else begin
                e.state = 4'd7; e.dm = 1'b1; e.ret = 1'b1; exp_q.push_back(e);
            end
        end else if (beq) begin
            e = mk(4'd8); e.opt = 2'b01; e.ext = 2'b01; e.pcs = 2'b01;
            e.pcw = z; e.ret = 1'b1; exp_q.push_back(e);
        end else if (jj) begin
            e = mk(4'd9); e.pcs = 2'b10; e.pcw = 1'b1; e.ret = 1'b1; exp_q.push_back(e);
        end
    endfunction

    task automatic chk(input string tag, input outv_t o, input outv_t e);
        ncmp++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Runs ncyc cycles of an instruction (all of them when ncyc < 0); entered just after an edge.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int w,
                             input int ncyc, input string tag);
        int n;
        build(ins, z, w);
        in_instr = ins;
        in_zero  = z;
        n = (ncyc < 0) ? exp_q.size() : ncyc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_c%0d", tag, i), obs, exp_q[i]);
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0: return {6'd0, rs, rt, rd, 5'd0, 6'h21};
            1: return {6'd0, rs, rt, rd, 5'd0, 6'h23};
            2: return {6'h0D, rs, rt, imm};
            3: return {6'h23, rs, rt, imm};
            4: return {6'h2B, rs, rt, imm};
            5: return {6'h04, rs, rt, imm};
            6: return {6'h0F, 5'd0, rt, imm};
            7: return {6'h02, 26'($urandom)};
            8: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        outv_t e;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_idle", obs0, mk(4'd0));
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(32'h00851021, 1'b0, 0, -1, "addu");
        run_instr(32'h8C820004, 1'b0, 0, -1, "lw");
        run_instr(32'hAC820004, 1'b0, 0, -1, "sw");
        run_instr(32'h10850003, 1'b1, 0, -1, "beq_taken");
        run_instr(32'h10850003, 1'b0, 0, -1, "beq_not");
        run_instr(32'h0085102A, 1'b0, 0, -1, "illegal");
        run_instr(32'h00000000, 1'b0, 0, -1, "nop");
        run_instr(32'h3C0A1234, 1'b0, 0, -1, "lui");
        run_instr(32'h34A5F00F, 1'b0, 0, -1, "ori");

        for (int k = 0; k < 60; k++) begin
            run_instr(rand_instr(), 1'($urandom), 0, -1, $sformatf("rand%0d", k));
        end

        // lw interrupted by reset in its MEMWB cycle: no write-back, clean restart.
        run_instr(32'h8C820004, 1'b0, 0, 4, "lw_part");
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_memwb", obs0, mk(4'd6));
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(32'h00851021, 1'b0, 0, -1, "after_rst");

        sel = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(32'h08000010, 1'b0, 3, -1, "w3_j");
        for (int k = 0; k < 10; k++) begin
            run_instr(rand_instr(), 1'($urandom), 3, -1, $sformatf("w3_rand%0d", k));
        end
        @(negedge clk);
        e = mk(4'd0);
        chk("w3_final_fetch", obs3, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS-subset datapath.
- Produces the ALU operation and operand-source encodings the ALU consumes, plus every datapath write-enable and mux select.
- Sits between the instruction register (opcode/funct/zero feedback) and the datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB-style states.

Parameters:
- IMEM_WAIT, 0: extra stall cycles spent in FETCH before the instruction is captured (0..15).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_instr  in  32  current IR contents; stable from DECODE until return to FETCH
- in_zero  in  1  ALU equality flag (opA == opB)
- out_alu_option  out  2  00 add, 01 sub, 10 or
- out_alu_src  out  1  0 GRF operand B, 1 EXT immediate
- out_ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- out_pc_write  out  1  PC load enable
- out_pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
- out_ir_write  out  1  IR load enable
- out_grf_write  out  1  register-file write enable
- out_reg_dst  out  1  0 rt, 1 rd
- out_mem_to_reg  out  1  0 ALU result, 1 DM data
- out_dm_write  out  1  data-memory write enable
- out_illegal  out  1  one-cycle pulse on an unsupported encoding
- out_retire  out  1  one-cycle pulse in the last cycle of each instruction
- out_state  out  4  current state code, for debug

Behaviour:
- Reset: synchronous, active-high. On a clk edge with reset=1, state <= FETCH and the wait counter <= 0. Reset overrides any state, including a cycle mid-instruction; no partial write-back follows.
- While reset is high, every enable and pulse output is 0. out_alu_option=00, out_alu_src=0, out_ext_op=00, out_pc_src=00, out_reg_dst=0, out_mem_to_reg=0.
- Outputs are Moore-style: combinational from the state register plus in_instr/in_zero. No output is registered.
- Any output not named for a state takes the reset/default value above.
- Decoded instructions: opcode in_instr[31:26], funct in_instr[5:0].
  - addu: op 000000, funct 100001
  - subu: op 000000, funct 100011
  - ori: 001101; lw: 100011; sw: 101011; beq: 000100; lui: 001111; j: 000010
- State codes: FETCH=0, DECODE=1, EXEC=2, ALUWB=3, MEMADR=4, MEMRD=5, MEMWB=6, MEMWR=7, BRANCH=8, JUMP=9.
- FETCH:
  - Stays in FETCH for IMEM_WAIT cycles, then one capture cycle.
  - Capture cycle only: out_ir_write=1, out_pc_write=1, out_pc_src=00. Then goes to DECODE.
  - Wait counter restarts at 0 on every FETCH entry.
- DECODE:
  - addu/subu/ori/lui -> EXEC; lw/sw -> MEMADR; beq -> BRANCH; j -> JUMP.
  - in_instr == 0 (nop) -> FETCH with out_retire=1.
  - Any other encoding, including R-type with unlisted funct -> FETCH with out_illegal=1 and out_retire=1.
- EXEC (ALU source and op by instruction):
  - addu: option 00, src 0.
  - subu: option 01, src 0.
  - ori: option 10, src 1, ext 00.
  - lui: option 10, src 1, ext 10 (rs field is $0, so result = imm<<16).
  - Next state: ALUWB.
- ALUWB: out_grf_write=1; out_reg_dst=1 for R-type, 0 otherwise; out_mem_to_reg=0; out_retire=1; -> FETCH. The ext/alu signals from EXEC are held.
- MEMADR: option 00, src 1, ext 01. lw -> MEMRD; sw -> MEMWR.
- MEMRD: address signals held as in MEMADR; -> MEMWB.
- MEMWB: out_grf_write=1, out_reg_dst=0, out_mem_to_reg=1, out_retire=1; -> FETCH.
- MEMWR: address signals held; out_dm_write=1, out_retire=1; -> FETCH.
- BRANCH: option 01, src 0, ext 01, out_pc_src=01. out_pc_write = in_zero, sampled the same cycle. out_retire=1; -> FETCH.
- JUMP: out_pc_src=10, out_pc_write=1, out_retire=1; -> FETCH.
- Latency in cycles with IMEM_WAIT=0:
  - R-type/ori/lui 4, lw 5, sw 4, beq 3, j 3, nop/illegal 2.
  - Each FETCH is extended by IMEM_WAIT.
- At most one of out_grf_write/out_dm_write is high in any cycle.
- out_pc_write is high only in FETCH capture, in BRANCH with in_zero=1, and in JUMP.
- Illegal states 10..15 -> FETCH on the next edge, with all enables 0.

Test Plan:
- Reset asserted mid-instruction: assert reset during MEMWB of a lw -> out_grf_write=0 that cycle; out_state=0 on the next edge; first FETCH captures with out_ir_write=1.
- addu: in_instr=0x00851021 -> states 0,1,2,3. EXEC shows option=00, src=0. ALUWB shows grf_write=1, reg_dst=1, retire=1. Total 4 cycles.
- lw then sw: lw 0x8C820004 -> 5 cycles, MEMWB mem_to_reg=1, reg_dst=0. sw 0xAC820004 -> 4 cycles, MEMWR dm_write=1, grf_write=0. Both show ext_op=01, src=1.
- beq, both branch outcomes: 0x10850003 with in_zero=1 -> BRANCH shows pc_write=1, pc_src=01, option=01. With in_zero=0 -> pc_write=0. Both take 3 cycles.
- Illegal and nop: instruction with funct 101010 -> out_illegal pulses exactly 1 cycle in DECODE, FETCH follows. 0x00000000 -> out_illegal=0, out_retire=1, 2 cycles.
- IMEM_WAIT=3 with j 0x08000010: ir_write is low for 3 cycles and then high 1 cycle. JUMP shows pc_write=1, pc_src=10. Total 6 cycles.
